// File: rtl/mem_share_ctrl.sv
`timescale 1ns/1ps
// mem_share_ctrl: round-robin sharing of one single-port, synchronous-read
// memory between two requesters (A and B). One operation at a time; read data
// is routed back to the requester that issued the read, with a valid pulse.
module mem_share_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    // requester A
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] add_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    // requester B
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] add_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    // memory side
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // requester encoding used for last_gnt and read ownership
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    state_t              state_q;
    logic                last_gnt_q;
    logic                rd_owner_q;
    logic                gnt_a_q;
    logic                gnt_b_q;
    logic                rvalid_a_q;
    logic                rvalid_b_q;
    logic [DATA_W-1:0]   rdata_a_q;
    logic [DATA_W-1:0]   rdata_b_q;
    logic                mem_rd_q;
    logic                mem_wr_q;
    logic [ADDR_W-1:0]   mem_add_q;
    logic [DATA_W-1:0]   mem_din_q;
    logic                busy_q;

    // arbitration result for the current IDLE cycle
    logic                win_valid_d;
    logic                win_b_d;
    logic                win_we_d;
    logic [ADDR_W-1:0]   win_add_d;
    logic [DATA_W-1:0]   win_wdata_d;

    // Round-robin pick: a lone requester always wins; on a tie the side that
    // was not granted last time goes first.
    always_comb begin
        win_valid_d = req_a | req_b;
        win_b_d     = req_b & (~req_a | (last_gnt_q == SEL_A));
        win_we_d    = win_b_d ? we_b    : we_a;
        win_add_d   = win_b_d ? add_b   : add_a;
        win_wdata_d = win_b_d ? wdata_b : wdata_a;
    end

    // Controller FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= SEL_B;
            rd_owner_q <= SEL_A;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_add_q  <= '0;
            mem_din_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_valid_d) begin
                        mem_add_q  <= win_add_d;
                        mem_din_q  <= win_wdata_d;
                        mem_wr_q   <= win_we_d;
                        mem_rd_q   <= ~win_we_d;
                        gnt_a_q    <= ~win_b_d;
                        gnt_b_q    <= win_b_d;
                        last_gnt_q <= win_b_d;
                        rd_owner_q <= win_b_d;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // a write is complete once its strobe has been shown
                    if (mem_wr_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // mem_dout is valid now; only the owner's rdata changes
                    if (rd_owner_q == SEL_B) begin
                        rdata_b_q  <= mem_dout;
                        rvalid_b_q <= 1'b1;
                    end else begin
                        rdata_a_q  <= mem_dout;
                        rvalid_a_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_a    = gnt_a_q;
    assign gnt_b    = gnt_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;
    assign mem_add  = mem_add_q;
    assign mem_din  = mem_din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_share_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_share_ctrl: stimulus pushes expected grants and
// read data; a negedge monitor pops and compares whenever the DUT shows gnt or
// rvalid. A simple synchronous-read memory model sits on the memory port.
module tb_mem_share_ctrl;

    logic       clk;
    logic       rst;
    logic       req_a, we_a, req_b, we_b;
    logic [2:0] add_a, add_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [7:0] rdata_a, rdata_b;
    logic       mem_rd, mem_wr, busy;
    logic [2:0] mem_add;
    logic [7:0] mem_din, mem_dout;
    logic       preload;

    typedef struct {
        logic       who;   // 0 = A, 1 = B
        logic       we;
        logic [2:0] add;
        logic [7:0] data;
    } op_t;

    op_t        exp_ops[$];
    logic [7:0] exp_rd_a[$];
    logic [7:0] exp_rd_b[$];
    int         gnt_cyc[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         rd_gnt_cyc_a = -100;
    int         rd_gnt_cyc_b = -100;
    logic [7:0] mem_model [8];

    mem_share_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .add_a(add_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .add_b(add_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_add(mem_add),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read memory: data appears the cycle after mem_rd
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) mem_model[i] <= 8'(i * 17);
        end else begin
            if (mem_wr) mem_model[mem_add] <= mem_din;
            if (mem_rd) mem_dout <= mem_model[mem_add];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt_a"}, 32'(gnt_a), 0);
        chk({tag, "_gnt_b"}, 32'(gnt_b), 0);
        chk({tag, "_rvalid_a"}, 32'(rvalid_a), 0);
        chk({tag, "_rvalid_b"}, 32'(rvalid_b), 0);
        chk({tag, "_rdata_a"}, 32'(rdata_a), 0);
        chk({tag, "_rdata_b"}, 32'(rdata_b), 0);
        chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 0);
        chk({tag, "_mem_add"}, 32'(mem_add), 0);
        chk({tag, "_mem_din"}, 32'(mem_din), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // monitor: compare against the scoreboard whenever the DUT presents output
    always @(negedge clk) begin
        if (!rst) begin
            op_t op;
            if (gnt_a && gnt_b) chk("gnt_both", 32'({gnt_a, gnt_b}), 32'h1);
            if ((mem_rd || mem_wr) && !(gnt_a || gnt_b)) chk("strobe_without_gnt", 32'({mem_rd, mem_wr}), 0);
            if (gnt_a || gnt_b) begin
                gnt_cyc.push_back(cyc);
                $display("cycle %0d: gnt %s rd=%0b wr=%0b add=%0d din=%02h", cyc,
                         gnt_b ? "B" : "A", mem_rd, mem_wr, mem_add, mem_din);
                if (exp_ops.size() == 0) begin
                    chk("gnt_unexpected", 32'({gnt_a, gnt_b}), 0);
                end else begin
                    op = exp_ops.pop_front();
                    chk("gnt_owner", 32'(gnt_b), 32'(op.who));
                    chk("mem_wr", 32'(mem_wr), 32'(op.we));
                    chk("mem_rd", 32'(mem_rd), 32'(!op.we));
                    chk("mem_add", 32'(mem_add), 32'(op.add));
                    if (op.we) chk("mem_din", 32'(mem_din), 32'(op.data));
                    chk("busy_at_gnt", 32'(busy), 1);
                    if (!op.we && !op.who) rd_gnt_cyc_a = cyc;
                    if (!op.we && op.who)  rd_gnt_cyc_b = cyc;
                end
            end
            if (rvalid_a) begin
                $display("cycle %0d: rvalid A rdata=%02h", cyc, rdata_a);
                chk("rvalid_a_excl", 32'(rvalid_b), 0);
                chk("rvalid_a_latency", 32'(cyc), 32'(rd_gnt_cyc_a + 2));
                if (exp_rd_a.size() == 0) chk("rvalid_a_unexpected", 32'(rvalid_a), 0);
                else chk("rdata_a", 32'(rdata_a), 32'(exp_rd_a.pop_front()));
            end
            if (rvalid_b) begin
                $display("cycle %0d: rvalid B rdata=%02h", cyc, rdata_b);
                chk("rvalid_b_excl", 32'(rvalid_a), 0);
                chk("rvalid_b_latency", 32'(cyc), 32'(rd_gnt_cyc_b + 2));
                if (exp_rd_b.size() == 0) chk("rvalid_b_unexpected", 32'(rvalid_b), 0);
                else chk("rdata_b", 32'(rdata_b), 32'(exp_rd_b.pop_front()));
            end
        end
    end

    // wait (bounded) for the given requester's grant; returns at gnt cycle + #1
    task automatic wait_gnt(input logic who, input string name);
        bit seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if ((who && gnt_b) || (!who && gnt_a)) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk({name, "_gnt_timeout"}, 0, 1);
    endtask

    task automatic drive(input logic who, input logic r, input logic we, input logic [2:0] add, input logic [7:0] wd);
        if (who) begin
            req_b = r; we_b = we; add_b = add; wdata_b = wd;
        end else begin
            req_a = r; we_a = we; add_a = add; wdata_a = wd;
        end
    endtask

    // one isolated request; expected grant (and read data) queued up front
    task automatic do_op(input logic who, input logic we, input logic [2:0] add, input logic [7:0] wd, input logic [7:0] exp_rd, input string name);
        op_t op;
        op.who = who; op.we = we; op.add = add; op.data = wd;
        exp_ops.push_back(op);
        if (!we) begin
            if (who) exp_rd_b.push_back(exp_rd);
            else     exp_rd_a.push_back(exp_rd);
        end
        @(posedge clk); #1;
        drive(who, 1'b1, we, add, wd);
        wait_gnt(who, name);
        drive(who, 1'b0, 1'b0, 3'd0, 8'h00);
        if (!we) repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero("rst_held");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        op_t op;
        int  n;
        rst = 1'b1; preload = 1'b1;
        req_a = 0; we_a = 0; add_a = 0; wdata_a = 0;
        req_b = 0; we_b = 0; add_b = 0; wdata_b = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        preload = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_zero("after_reset");

        // test 1: A writes A5 to address 2, idle the following cycle
        do_op(1'b0, 1'b1, 3'd2, 8'hA5, 8'h00, "t1");
        @(posedge clk); #1;
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_wr_after", 32'(mem_wr), 0);
        chk("t1_rd_after", 32'(mem_rd), 0);

        // test 2: A reads back address 2; rdata_a must hold afterwards
        do_op(1'b0, 1'b0, 3'd2, 8'h00, 8'hA5, "t2");
        repeat (3) @(posedge clk);
        #1;
        chk("t2_rdata_a_hold", 32'(rdata_a), 32'hA5);

        // test 3: both requesters read continuously -> A,B,A,B, 3 cycles apart
        do_reset();
        gnt_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            op.who = k[0]; op.we = 1'b0; op.add = k[0] ? 3'd6 : 3'd1; op.data = 8'h00;
            exp_ops.push_back(op);
        end
        exp_rd_a.push_back(8'h11); exp_rd_a.push_back(8'h11);
        exp_rd_b.push_back(8'h66); exp_rd_b.push_back(8'h66);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 3'd1, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 3'd6, 8'h00);
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(posedge clk); #1;
            if (gnt_a || gnt_b) n++;
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        chk("t3_grant_count", 32'(n), 4);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_gnt_cyc_count", 32'(gnt_cyc.size()), 4);
        if (gnt_cyc.size() == 4)
            for (int k = 1; k < 4; k++) chk("t3_gnt_spacing", 32'(gnt_cyc[k] - gnt_cyc[k-1]), 3);

        // test 4: B alone, 4 back-to-back writes -> gnt_b every 2 cycles
        gnt_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            op.who = 1'b1; op.we = 1'b1; op.add = 3'(4 + k); op.data = 8'(8'hC0 + k);
            exp_ops.push_back(op);
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 3'd4, 8'hC0);
        for (int k = 0; k < 4; k++) begin
            wait_gnt(1'b1, "t4");
            if (k < 3) drive(1'b1, 1'b1, 1'b1, 3'(5 + k), 8'(8'hC1 + k));
            else       drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t4_gnt_cyc_count", 32'(gnt_cyc.size()), 4);
        if (gnt_cyc.size() == 4)
            for (int k = 1; k < 4; k++) chk("t4_gnt_spacing", 32'(gnt_cyc[k] - gnt_cyc[k-1]), 2);

        // test 5: reset during the WAIT cycle of an A read discards it
        op.who = 1'b0; op.we = 1'b0; op.add = 3'd3; op.data = 8'h00;
        exp_ops.push_back(op);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 3'd3, 8'h00);
        wait_gnt(1'b0, "t5");
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        @(posedge clk); #1;
        chk("t5_busy_in_wait", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero("t5_after_rst");
        rst = 1'b0;
        do_op(1'b1, 1'b0, 3'd5, 8'h00, 8'hC1, "t5b");
        repeat (2) @(posedge clk);
        #1;
        chk("t5_rdata_a_untouched", 32'(rdata_a), 0);

        // test 6: fresh memory image, B reads every address in turn
        @(posedge clk); #1;
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        for (int k = 0; k < 8; k++)
            do_op(1'b1, 1'b0, 3'(k), 8'h00, 8'(k * 17), "t6");

        repeat (5) @(posedge clk);
        #1;
        chk("left_exp_ops", 32'(exp_ops.size()), 0);
        chk("left_exp_rd_a", 32'(exp_rd_a.size()), 0);
        chk("left_exp_rd_b", 32'(exp_rd_b.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_share_ctrl.md
Name: mem_share_ctrl

Overview:
- Controller that shares one single-port, synchronous-read 8x8 memory between two requesters, A and B.
- Arbitrates round-robin and issues one memory operation at a time on the memory-side port.
- Returns read data to the requester that issued the read, with a valid pulse.
- Sits between the two client blocks and the memory instance; the memory is external to this block.

Parameters:
ADDR_W, 3, address width (memory depth 2**ADDR_W = 8)
DATA_W, 8, data width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_a  input  1  requester A access request, held until gnt_a
we_a  input  1  A: 1 = write, 0 = read; stable while req_a high
add_a  input  ADDR_W  A address; stable while req_a high
wdata_a  input  DATA_W  A write data; stable while req_a high
gnt_a  output  1  one-cycle pulse: A's request accepted
rvalid_a  output  1  one-cycle pulse: rdata_a holds A's read result
rdata_a  output  DATA_W  A read data, held until next rvalid_a
req_b, we_b, add_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as A, for requester B
mem_rd  output  1  memory read strobe, one cycle
mem_wr  output  1  memory write strobe, one cycle
mem_add  output  ADDR_W  memory address
mem_din  output  DATA_W  memory write data
mem_dout  input  DATA_W  memory read data, valid the cycle after mem_rd
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset is sampled on the rising edge of clk and, when high, overrides every other input.
- Reset values: state = IDLE; all outputs 0 (gnt, rvalid, rdata, mem_*, busy); last_gnt = B, so A wins the first tie.
- FSM states: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE: at the clock edge, sample req_a/req_b.
  - Neither high: stay in IDLE.
  - One high: that requester wins.
  - Both high: the requester not equal to last_gnt wins.
  - Winner: latch its we/add/wdata into mem_add/mem_din, set mem_wr = we or mem_rd = !we, set gnt_x = 1, update last_gnt, go to ISSUE.
- ISSUE (1 cycle): gnt_x, the strobe, mem_add and mem_din are visible this cycle.
  - Next: write -> IDLE; read -> WAIT.
  - Strobes and gnt drop after this cycle; mem_add and mem_din hold their last value.
- WAIT (1 cycle): mem_dout is valid. Capture it into rdata_x of the read's owner, pulse rvalid_x in the following cycle, go to IDLE. Arbitration in that IDLE cycle proceeds normally.
- Latency (request sampled at edge ending cycle T):
  - gnt and strobe appear in T+1.
  - Write done; next arbitration at the edge ending T+2.
  - Read: rvalid/rdata appear in T+3.
- Throughput: write every 2 cycles, read every 3 cycles.
- Requester rule: after seeing gnt, a requester deasserts req, or presents a new request, no later than the next cycle. Req still high in IDLE is treated as a new request.
- Round robin: no slot is skipped. A lone requester is served every opportunity regardless of last_gnt.
- rvalid_a and rvalid_b are never high in the same cycle. The non-owner's rdata is untouched.
- Requests arriving while busy are ignored until IDLE; no queuing.
- Reset mid-operation (ISSUE or WAIT): return to IDLE next cycle; the in-flight read is discarded (no rvalid); all outputs are 0.
- Address: passed through unchanged, no wrap logic; all 2**ADDR_W addresses are legal.

Test Plan:
1. Reset, then req_a=1, we_a=1, add_a=3'b010, wdata_a=8'hA5 in cycle 0 -> cycle 1: gnt_a=1, mem_wr=1, mem_add=2, mem_din=8'hA5, busy=1; cycle 2: busy=0, no strobes.
2. A reads add 3'b010, model returns 8'hA5 -> cycle 1: gnt_a, mem_rd=1; cycle 3: rvalid_a=1, rdata_a=8'hA5, rvalid_b=0; rdata_a holds 8'hA5 afterwards.
3. After reset, req_a and req_b high continuously, all reads -> grant order A,B,A,B; gnt pulses 3 cycles apart; rvalid ownership matches.
4. Only req_b high, 4 back-to-back writes -> gnt_b every 2 cycles; gnt_a never asserted.
5. rst asserted in the WAIT cycle of an A read -> next cycle all outputs 0, no rvalid_a; after release, a B read of add 5 completes normally.
6. B reads add 0..7 sequentially, model data = add*8'h11 -> rdata_b sequence 00,11,22,33,44,55,66,77, each with a single rvalid_b pulse.
